ysyx_24100029_idu: RTL and testbench

Four-wide instruction decode stage directly downstream of the fetch unit. Accepts up to four in-order instructions per cycle through the fetch valid/ready prefix handshake and decodes each as RV32IM + Zicsr. Results go into a 4-entry packed output register, which feeds rename/dispatch through a second per-slot prefix handshake. A flush discards all held state on a redirect.

---
 rtl/ysyx_24100029_idu.sv | 241 ++++++++++++++++++++++++
 tb/tb_ysyx_24100029_idu.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100029_idu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24100029_idu
// Purpose  : Four-wide RV32IM + Zicsr decode stage. Takes up to four in-order
//            instructions per cycle from fetch and decodes them combinationally.
//            Accepted results go into a packed 4-entry output register, which
//            is drained by rename/dispatch.
// Ports    : clock, reset (async, active-high), flush (redirect)
//            in_inst/in_pc/in_valid/in_ready    - fetch side, prefix handshake
//            out_valid/out_ready                - dispatch side, prefix handshake
//            out_pc/out_inst/out_rd/out_rs1/out_rs2/out_rd_wen/out_rs1_ren/
//            out_rs2_ren/out_imm/out_fu/out_illegal - per-slot decoded payload
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_24100029_idu #(
  parameter int ADDR_WIDTH = 32,
  parameter int SLOTS      = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [SLOTS*32-1:0]         in_inst,
  input  logic [SLOTS*ADDR_WIDTH-1:0] in_pc,
  input  logic [SLOTS-1:0]            in_valid,
  output logic [SLOTS-1:0]            in_ready,
  output logic [SLOTS-1:0]            out_valid,
  input  logic [SLOTS-1:0]            out_ready,
  output logic [SLOTS*ADDR_WIDTH-1:0] out_pc,
  output logic [SLOTS*32-1:0]         out_inst,
  output logic [SLOTS*5-1:0]          out_rd,
  output logic [SLOTS*5-1:0]          out_rs1,
  output logic [SLOTS*5-1:0]          out_rs2,
  output logic [SLOTS-1:0]            out_rd_wen,
  output logic [SLOTS-1:0]            out_rs1_ren,
  output logic [SLOTS-1:0]            out_rs2_ren,
  output logic [SLOTS*32-1:0]         out_imm,
  output logic [SLOTS*3-1:0]          out_fu,
  output logic [SLOTS-1:0]            out_illegal
);

  localparam logic [2:0] c_slots   = 3'd4;

  localparam logic [2:0] c_fu_alu  = 3'd0;
  localparam logic [2:0] c_fu_bru  = 3'd1;
  localparam logic [2:0] c_fu_load = 3'd2;
  localparam logic [2:0] c_fu_stor = 3'd3;
  localparam logic [2:0] c_fu_mdu  = 3'd4;
  localparam logic [2:0] c_fu_sys  = 3'd5;

  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_imm    = 7'b0010011;
  localparam logic [6:0] c_op_reg    = 7'b0110011;
  localparam logic [6:0] c_op_fence  = 7'b0001111;
  localparam logic [6:0] c_op_system = 7'b1110011;

  localparam logic [31:0] c_ecall  = 32'h0000_0073;
  localparam logic [31:0] c_ebreak = 32'h0010_0073;
  localparam logic [31:0] c_mret   = 32'h3020_0073;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [31:0]           inst;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic                  rd_wen;
    logic                  rs1_ren;
    logic                  rs2_ren;
    logic [31:0]           imm;
    logic [2:0]            fu;
    logic                  illegal;
  } entry_t;

  // Number of consecutive ones starting at bit 0 (a non-prefix mask is
  // truncated at its first zero).
  function automatic logic [2:0] lead_ones(input logic [3:0] v);
    if (!v[0])      return 3'd0;
    else if (!v[1]) return 3'd1;
    else if (!v[2]) return 3'd2;
    else if (!v[3]) return 3'd3;
    else            return 3'd4;
  endfunction

  function automatic logic is_prefix(input logic [3:0] v);
    return (v & (v + 4'd1)) == 4'd0;
  endfunction

  function automatic entry_t decode(input logic [31:0] inst,
                                    input logic [ADDR_WIDTH-1:0] pc);
    entry_t      e;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        legal;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    f3    = inst[14:12];
    f7    = inst[31:25];
    imm_i = {{20{inst[31]}}, inst[31:20]};
    imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    imm_u = {inst[31:12], 12'b0};
    imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    e       = '0;
    e.pc    = pc;
    e.inst  = inst;
    e.rd    = inst[11:7];
    e.rs1   = inst[19:15];
    e.rs2   = inst[24:20];
    legal   = 1'b1;
    case (inst[6:0])
      c_op_lui, c_op_auipc: begin
        e.rd_wen = 1'b1; e.imm = imm_u; e.fu = c_fu_alu;
      end
      c_op_jal: begin
        e.rd_wen = 1'b1; e.imm = imm_j; e.fu = c_fu_bru;
      end
      c_op_jalr: begin
        legal = (f3 == 3'b000);
        e.rd_wen = 1'b1; e.rs1_ren = 1'b1; e.imm = imm_i; e.fu = c_fu_bru;
      end
      c_op_branch: begin
        legal = (f3 != 3'b010) && (f3 != 3'b011);
        e.rs1_ren = 1'b1; e.rs2_ren = 1'b1; e.imm = imm_b; e.fu = c_fu_bru;
      end
      c_op_load: begin
        legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                (f3 == 3'b100) || (f3 == 3'b101);
        e.rd_wen = 1'b1; e.rs1_ren = 1'b1; e.imm = imm_i; e.fu = c_fu_load;
      end
      c_op_store: begin
        legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        e.rs1_ren = 1'b1; e.rs2_ren = 1'b1; e.imm = imm_s; e.fu = c_fu_stor;
      end
      c_op_imm: begin
        // Shift-immediates reuse funct7 as an opcode extension.
        if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
        else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        e.rd_wen = 1'b1; e.rs1_ren = 1'b1; e.imm = imm_i; e.fu = c_fu_alu;
      end
      c_op_reg: begin
        e.rd_wen = 1'b1; e.rs1_ren = 1'b1; e.rs2_ren = 1'b1;
        if (f7 == 7'b0000001)      e.fu = c_fu_mdu;
        else if (f7 == 7'b0100000) legal = (f3 == 3'b000) || (f3 == 3'b101);
        else if (f7 != 7'b0000000) legal = 1'b0;
      end
      c_op_fence: begin
        legal = (f3 == 3'b000);
        e.imm = imm_i; e.fu = c_fu_sys;
      end
      c_op_system: begin
        e.fu = c_fu_sys;
        if (f3 == 3'b000) begin
          legal = (inst == c_ecall) || (inst == c_ebreak) || (inst == c_mret);
        end else if (f3 == 3'b100) begin
          legal = 1'b0;
        end else begin
          e.rd_wen = 1'b1;
          // funct3[2] selects the zimm form: rs1 field is a literal, not a register.
          if (f3[2]) e.imm = {27'b0, inst[19:15]};
          else       e.rs1_ren = 1'b1;
        end
      end
      default: legal = 1'b0;
    endcase
    if (e.rd == 5'd0) e.rd_wen = 1'b0;
    if (!legal) begin
      e.rd_wen  = 1'b0;
      e.rs1_ren = 1'b0;
      e.rs2_ren = 1'b0;
      e.imm     = '0;
      e.fu      = c_fu_alu;
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  logic [2:0] occ_q, occ_d;
  entry_t     ent_q [SLOTS];
  entry_t     ent_d [SLOTS];
  entry_t     w_dec [SLOTS];
  logic [2:0] w_k, w_m, w_base;

  for (genvar j = 0; j < SLOTS; j++) begin : g_slot
    assign w_dec[j]     = decode(in_inst[32*j +: 32], in_pc[ADDR_WIDTH*j +: ADDR_WIDTH]);
    assign out_valid[j] = (3'(j) < occ_q) & ~flush;
    // Free space is judged from the registered occupancy only, so a drain
    // this cycle does not open intake until the next one.
    assign in_ready[j]  = (3'(j) < (c_slots - occ_q)) & ~flush & ~reset;

    assign out_pc[ADDR_WIDTH*j +: ADDR_WIDTH] = ent_q[j].pc;
    assign out_inst[32*j +: 32] = ent_q[j].inst;
    assign out_rd[5*j +: 5]     = ent_q[j].rd;
    assign out_rs1[5*j +: 5]    = ent_q[j].rs1;
    assign out_rs2[5*j +: 5]    = ent_q[j].rs2;
    assign out_rd_wen[j]        = ent_q[j].rd_wen;
    assign out_rs1_ren[j]       = ent_q[j].rs1_ren;
    assign out_rs2_ren[j]       = ent_q[j].rs2_ren;
    assign out_imm[32*j +: 32]  = ent_q[j].imm;
    assign out_fu[3*j +: 3]     = ent_q[j].fu;
    assign out_illegal[j]       = ent_q[j].illegal;
  end

  // Shift survivors down by k, then append the m accepted instructions
  // directly behind them.
  always_comb begin
    w_k    = lead_ones(out_valid & out_ready);
    w_m    = lead_ones(in_valid & in_ready);
    w_base = occ_q - w_k;
    occ_d  = w_base + w_m;
    for (int j = 0; j < SLOTS; j++) begin
      ent_d[j] = ent_q[j];
      if (!flush) begin
        if (3'(j) < w_base)     ent_d[j] = ent_q[2'(j) + w_k[1:0]];
        else if (3'(j) < occ_d) ent_d[j] = w_dec[2'(j) - w_base[1:0]];
      end
    end
    if (flush) occ_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occ_q <= '0;
      for (int j = 0; j < SLOTS; j++) ent_q[j] <= '0;
    end else begin
      occ_q <= occ_d;
      for (int j = 0; j < SLOTS; j++) ent_q[j] <= ent_d[j];
    end
  end

  // Downstream must consume in order; a gap in its acceptance is a protocol bug.
  always_ff @(posedge clock) begin
    if (!reset && !flush) assert (is_prefix(out_valid & out_ready));
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24100029_idu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_24100029_idu
// Purpose  : Directed self-checking bench for the four-wide decode stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_24100029_idu;

  logic         clock = 1'b0;
  logic         reset;
  logic         flush;
  logic [127:0] in_inst;
  logic [127:0] in_pc;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [127:0] out_pc;
  logic [127:0] out_inst;
  logic [19:0]  out_rd, out_rs1, out_rs2;
  logic [3:0]   out_rd_wen, out_rs1_ren, out_rs2_ren;
  logic [127:0] out_imm;
  logic [11:0]  out_fu;
  logic [3:0]   out_illegal;

  int n_check = 0;
  int n_pass  = 0;

  ysyx_24100029_idu #(.ADDR_WIDTH(32), .SLOTS(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .in_inst     (in_inst),
    .in_pc       (in_pc),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .out_rd      (out_rd),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_rd_wen  (out_rd_wen),
    .out_rs1_ren (out_rs1_ren),
    .out_rs2_ren (out_rs2_ren),
    .out_imm     (out_imm),
    .out_fu      (out_fu),
    .out_illegal (out_illegal)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_check++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input int j, input logic [31:0] inst, input logic [31:0] pc);
    in_inst[32*j +: 32] = inst;
    in_pc[32*j +: 32]   = pc;
  endtask

  function automatic logic [3:0] mask(input int n);
    return 4'((1 << n) - 1);
  endfunction

  int mocc;
  logic [31:0] fpc, opc;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = '0; out_ready = '0;
    in_inst = '0; in_pc = '0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready",  32'(in_ready),  32'h0);
    check("rst_pc0",       out_pc[31:0],   32'h0);
    check("rst_imm3",      out_imm[127:96], 32'h0);
    @(posedge clock); @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("rel_in_ready",  32'(in_ready),  32'hF);
    check("rel_out_valid", 32'(out_valid), 32'h0);

    // Decode check: addi, lw, sw, jal x0,-8
    put(0, 32'h00500093, 32'h10000000);
    put(1, 32'h0080A103, 32'h10000004);
    put(2, 32'h0020A623, 32'h10000008);
    put(3, 32'hFF9FF06F, 32'h1000000C);
    in_valid = 4'hF;
    #1;
    cyc();
    in_valid = 4'h0;
    #1;
    check("full_out_valid", 32'(out_valid), 32'hF);
    check("full_in_ready",  32'(in_ready),  32'h0);
    check("addi_rd",   32'(out_rd[4:0]),    32'd1);
    check("addi_rs1",  32'(out_rs1[4:0]),   32'd0);
    check("addi_imm",  out_imm[31:0],       32'd5);
    check("addi_fu",   32'(out_fu[2:0]),    32'd0);
    check("addi_wen",  32'(out_rd_wen[0]),  32'd1);
    check("lw_rd",     32'(out_rd[9:5]),    32'd2);
    check("lw_rs1",    32'(out_rs1[9:5]),   32'd1);
    check("lw_imm",    out_imm[63:32],      32'd8);
    check("lw_fu",     32'(out_fu[5:3]),    32'd2);
    check("sw_rs1",    32'(out_rs1[14:10]), 32'd1);
    check("sw_rs2",    32'(out_rs2[14:10]), 32'd2);
    check("sw_imm",    out_imm[95:64],      32'd12);
    check("sw_fu",     32'(out_fu[8:6]),    32'd3);
    check("sw_wen",    32'(out_rd_wen[2]),  32'd0);
    check("sw_ren2",   32'(out_rs2_ren[2]), 32'd1);
    check("jal_fu",    32'(out_fu[11:9]),   32'd1);
    check("jal_imm",   out_imm[127:96],     32'hFFFFFFF8);
    check("jal_wen",   32'(out_rd_wen[3]),  32'd0);
    check("jal_ill",   32'(out_illegal[3]), 32'd0);
    check("pc3",       out_pc[127:96],      32'h1000000C);

    // Backpressure: occ=4, drain one
    out_ready = 4'b0001;
    in_valid  = 4'hF;
    for (int j = 0; j < 4; j++) put(j, 32'h00500093, 32'h50000000 + 32'(4*j));
    #1;
    check("bp_in_ready", 32'(in_ready), 32'h0);
    cyc();
    out_ready = 4'b0000;
    put(0, 32'h00000000, 32'h40000000);
    #1;
    check("bp_in_ready2",  32'(in_ready),  32'h1);
    check("bp_out_valid",  32'(out_valid), 32'h7);
    check("bp_slot0_pc",   out_pc[31:0],   32'h10000004);
    check("bp_slot0_fu",   32'(out_fu[2:0]), 32'd2);
    cyc();
    in_valid = 4'h0;
    #1;
    check("ill_out_valid", 32'(out_valid),      32'hF);
    check("ill_pc",        out_pc[127:96],      32'h40000000);
    check("ill_flag",      32'(out_illegal[3]), 32'd1);
    check("ill_fu",        32'(out_fu[11:9]),   32'd0);
    check("ill_wen",       32'(out_rd_wen[3]),  32'd0);
    check("ill_slot2_pc",  out_pc[95:64],       32'h1000000C);

    // Partial intake: drain two, then offer four
    out_ready = 4'b0011;
    cyc();
    out_ready = 4'b0000;
    in_valid  = 4'hF;
    for (int j = 0; j < 4; j++) put(j, 32'h00500093, 32'h20000000 + 32'(4*j));
    #1;
    check("pi_in_ready",  32'(in_ready),  32'h3);
    check("pi_out_valid", 32'(out_valid), 32'h3);
    cyc();
    in_valid = 4'h0;
    #1;
    check("pi_out_valid2", 32'(out_valid), 32'hF);
    check("pi_slot0_pc",   out_pc[31:0],   32'h1000000C);
    check("pi_slot1_pc",   out_pc[63:32],  32'h40000000);
    check("pi_slot2_pc",   out_pc[95:64],  32'h20000000);
    check("pi_slot3_pc",   out_pc[127:96], 32'h20000004);

    // Flush at occ=3 while fetch offers four
    out_ready = 4'b0001;
    cyc();
    out_ready = 4'b0000;
    #1;
    check("fl_pre_valid", 32'(out_valid), 32'h7);
    flush    = 1'b1;
    in_valid = 4'hF;
    #1;
    check("fl_out_valid", 32'(out_valid), 32'h0);
    check("fl_in_ready",  32'(in_ready),  32'h0);
    cyc();
    flush = 1'b0;
    #1;
    check("fl_next_valid", 32'(out_valid), 32'h0);
    check("fl_next_ready", 32'(in_ready),  32'hF);

    // Streaming with full drain: occupancy alternates 0/4, PCs stay contiguous
    out_ready = 4'hF;
    in_valid  = 4'hF;
    mocc = 0;
    fpc  = 32'h30000000;
    opc  = 32'h30000000;
    for (int it = 0; it < 8; it++) begin
      for (int j = 0; j < 4; j++) put(j, 32'h00500093, fpc + 32'(4*j));
      #1;
      check("st_in_ready",  32'(in_ready),  32'(mask(4 - mocc)));
      check("st_out_valid", 32'(out_valid), 32'(mask(mocc)));
      if (mocc != 0) begin
        check("st_pc_first", out_pc[31:0],                  opc);
        check("st_pc_last",  out_pc[32*(mocc-1) +: 32],     opc + 32'(4*(mocc-1)));
      end
      opc  = opc + 32'(4*mocc);
      fpc  = fpc + 32'(4*(4 - mocc));
      mocc = 4 - mocc;
      cyc();
    end

    // Async reset at occ=3
    in_valid = 4'h0;
    cyc();
    out_ready = 4'h0;
    in_valid  = 4'b0111;
    for (int j = 0; j < 4; j++) put(j, 32'h00500093, 32'h60000000 + 32'(4*j));
    cyc();
    in_valid = 4'h0;
    #1;
    check("ar_pre_valid", 32'(out_valid), 32'h7);
    #2 reset = 1'b1;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'h0);
    check("ar_in_ready",  32'(in_ready),  32'h0);
    check("ar_pc0",       out_pc[31:0],   32'h0);
    #10 reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
`default_nettype wire
